// File: rtl/playback_controller_if.sv
// Control/ROM bundle between the playback controller and its environment.
// The master side is the controller; the slave side is the tone/ROM/button environment.
interface playback_controller_if #(
  parameter int NOTE_W  = 6,
  parameter int TRACK_W = 2
);
  logic               play;
  logic               btn_next;
  logic               btn_prev;
  logic [3:0]         note_dur;
  logic [NOTE_W-1:0]  note_addr;
  logic [TRACK_W-1:0] track_sel;
  logic               mute;
  logic               note_start;
  logic               track_end;

  modport master (
    input  play, btn_next, btn_prev, note_dur,
    output note_addr, track_sel, mute, note_start, track_end
  );

  modport slave (
    output play, btn_next, btn_prev, note_dur,
    input  note_addr, track_sel, mute, note_start, track_end
  );
endinterface

// File: rtl/playback_controller.sv
// Song playback sequencer: walks note addresses of a track in the song ROM, times each
// note in prescaled ticks, and handles play/pause and next/prev track buttons.
module playback_controller #(
  parameter int TICK_DIV = 4,
  parameter int NOTE_W   = 6,
  parameter int TRACK_W  = 2
) (
  input  logic clk,
  input  logic reset,
  playback_controller_if.master bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]      PRESC_ONE  = PW'(1);
  localparam logic [NOTE_W-1:0]  ADDR_LAST  = {NOTE_W{1'b1}};
  localparam logic [NOTE_W-1:0]  ADDR_ONE   = NOTE_W'(1);
  localparam logic [TRACK_W-1:0] TRACK_ONE  = TRACK_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_FETCH = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [NOTE_W-1:0]  note_addr_q, note_addr_d;
  logic [TRACK_W-1:0] track_sel_q, track_sel_d;
  logic [3:0]         dur_reg_q, dur_reg_d;
  logic [3:0]         dur_cnt_q, dur_cnt_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic               mute_q, mute_d;
  logic               note_start_q, note_start_d;
  logic               track_end_q, track_end_d;
  logic               next_smp_q, prev_smp_q;
  logic               next_ev_s, prev_ev_s, btn_ev_s, end_track_s;

  // Simultaneous next and prev presses cancel each other out.
  assign next_ev_s = bus.btn_next & ~next_smp_q;
  assign prev_ev_s = bus.btn_prev & ~prev_smp_q;
  assign btn_ev_s  = next_ev_s ^ prev_ev_s;

  always_comb begin
    state_d      = state_q;
    note_addr_d  = note_addr_q;
    track_sel_d  = track_sel_q;
    dur_reg_d    = dur_reg_q;
    dur_cnt_d    = dur_cnt_q;
    presc_d      = presc_q;
    note_start_d = 1'b0;
    track_end_d  = 1'b0;
    end_track_s  = 1'b0;
    if (btn_ev_s) begin
      track_sel_d = next_ev_s ? (track_sel_q + TRACK_ONE) : (track_sel_q - TRACK_ONE);
      note_addr_d = '0;
      dur_cnt_d   = '0;
      presc_d     = '0;
      if ((state_q == S_IDLE) || (state_q == S_PAUSE)) state_d = S_IDLE;
      else                                             state_d = S_WAIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.play) state_d = S_WAIT;
          else          state_d = S_IDLE;
        end
        S_WAIT: state_d = S_FETCH;
        S_FETCH: begin
          dur_reg_d = bus.note_dur;
          dur_cnt_d = '0;
          presc_d   = '0;
          if (bus.note_dur == 4'd0) begin
            end_track_s = 1'b1;
          end else if (bus.play) begin
            state_d      = S_PLAY;
            note_start_d = 1'b1;
          end else begin
            state_d = S_PAUSE;
          end
        end
        // A paused cycle freezes the counters, so the note resumes exactly where it stopped.
        S_PLAY: begin
          if (!bus.play) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (dur_cnt_q == (dur_reg_q - 4'd1)) begin
              if (note_addr_q == ADDR_LAST) begin
                end_track_s = 1'b1;
              end else begin
                note_addr_d = note_addr_q + ADDR_ONE;
                state_d     = S_WAIT;
              end
            end else begin
              dur_cnt_d = dur_cnt_q + 4'd1;
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        S_PAUSE: begin
          if (bus.play) state_d = S_PLAY;
          else          state_d = S_PAUSE;
        end
        default: state_d = S_IDLE;
      endcase
      if (end_track_s) begin
        track_sel_d = track_sel_q + TRACK_ONE;
        note_addr_d = '0;
        track_end_d = 1'b1;
        state_d     = S_WAIT;
      end else begin
        track_end_d = 1'b0;
      end
    end
    mute_d = (state_d != S_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      note_addr_q  <= '0;
      track_sel_q  <= '0;
      dur_reg_q    <= 4'd0;
      dur_cnt_q    <= 4'd0;
      presc_q      <= '0;
      mute_q       <= 1'b1;
      note_start_q <= 1'b0;
      track_end_q  <= 1'b0;
      next_smp_q   <= 1'b0;
      prev_smp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      note_addr_q  <= note_addr_d;
      track_sel_q  <= track_sel_d;
      dur_reg_q    <= dur_reg_d;
      dur_cnt_q    <= dur_cnt_d;
      presc_q      <= presc_d;
      mute_q       <= mute_d;
      note_start_q <= note_start_d;
      track_end_q  <= track_end_d;
      next_smp_q   <= bus.btn_next;
      prev_smp_q   <= bus.btn_prev;
    end
  end

  assign bus.note_addr  = note_addr_q;
  assign bus.track_sel  = track_sel_q;
  assign bus.mute       = mute_q;
  assign bus.note_start = note_start_q;
  assign bus.track_end  = track_end_q;
endmodule

// File: tb/tb_playback_controller.sv
// Bench for playback_controller: directed scenarios plus randomized songs with random
// pauses, scored against a note-level model of the song ROM.
module tb_playback_controller;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playback_controller_if #(.NOTE_W(6), .TRACK_W(2)) bus ();
  playback_controller #(.TICK_DIV(TD), .NOTE_W(6), .TRACK_W(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Song ROM with one cycle of read latency.
  logic [3:0] rom [4][64];
  always @(posedge clk) bus.note_dur <= rom[bus.track_sel][bus.note_addr];

  int checks = 0;
  int errors = 0;

  typedef struct { bit is_end; int t; int a; int len; } exp_t;
  exp_t exp_q[$];
  bit mon_en = 1'b0;
  bit open_n = 1'b0;
  int cur_t, cur_a, cur_len;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.play = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_note(input string name);
    int n;
    n = 0;
    do begin tick(); n++; end while (!bus.note_start && n < 200);
    if (!bus.note_start) begin
      checks++;
      errors++;
      $display("FAIL %s: note_start got 0 required 1 within 200 cycles", name);
    end
  endtask

  task automatic fill_rom(input int d);
    for (int t = 0; t < 4; t++)
      for (int a = 0; a < 64; a++) rom[t][a] = 4'(d);
  endtask

  // Expected events from the song: each note lasts dur*TD playing cycles; a 0 marker or
  // the last address ends the track and moves to the next one.
  task automatic push_song();
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 64; a++) begin
        if (rom[t][a] == 4'd0) begin
          exp_q.push_back('{1'b1, (t + 1) % 4, 0, 0});
          break;
        end
        exp_q.push_back('{1'b0, t, a, int'(rom[t][a]) * TD});
        if (a == 63) exp_q.push_back('{1'b1, (t + 1) % 4, 0, 0});
      end
    end
  endtask

  task automatic sb_pop(input bit is_end, input int t, input int a, input int len);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got event end=%0d track=%0d addr=%0d required none", is_end, t, a);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_end != is_end) begin
      errors++;
      $display("FAIL sb_kind: got end=%0d required end=%0d (track %0d addr %0d)", is_end, e.is_end, e.t, e.a);
      return;
    end
    check("sb_track", t, e.t);
    if (!is_end) begin
      check("sb_addr", a, e.a);
      check("sb_len", len, e.len);
    end
  endtask

  // Monitor: a note is closed by the next note_start or track_end; its length counts the
  // cycles that were unmuted and not being paused.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (bus.track_end) begin
        if (open_n) begin
          sb_pop(1'b0, cur_t, cur_a, cur_len);
          open_n = 1'b0;
        end
        sb_pop(1'b1, int'(bus.track_sel), 0, 0);
        check("sb_end_addr", int'(bus.note_addr), 0);
      end
      if (bus.note_start) begin
        if (open_n) sb_pop(1'b0, cur_t, cur_a, cur_len);
        open_n  = 1'b1;
        cur_t   = int'(bus.track_sel);
        cur_a   = int'(bus.note_addr);
        cur_len = 0;
      end
      if (open_n && !bus.mute && bus.play) cur_len++;
    end
  end

  logic [19:0] mute_v, ns_v, te_v, mute_e, ns_e, te_e;
  int n, run, ns, last, ph, kc, mc, d, cyc, muted_lo;

  initial begin
    reset = 1'b1;
    fill_rom(0);
    rom[0][0] = 4'd2;
    rom[0][1] = 4'd1;

    // Reset state and idling with play low.
    do_reset();
    check("rst_addr", int'(bus.note_addr), 0);
    check("rst_track", int'(bus.track_sel), 0);
    check("rst_mute", int'(bus.mute), 1);
    check("rst_note_start", int'(bus.note_start), 0);
    check("rst_track_end", int'(bus.track_end), 0);
    repeat (4) tick();
    check("idle_mute", int'(bus.mute), 1);
    check("idle_addr", int'(bus.note_addr), 0);

    // Track {2,1,0}: cycle-by-cycle trace after play rises.
    bus.play = 1'b1;
    mute_v = '0; ns_v = '0; te_v = '0;
    for (int c = 1; c < 20; c++) begin
      tick();
      mute_v[c] = bus.mute;
      ns_v[c]   = bus.note_start;
      te_v[c]   = bus.track_end;
      if (c == 3)  check("trace_addr0", int'(bus.note_addr), 0);
      if (c == 13) check("trace_addr1", int'(bus.note_addr), 1);
    end
    mute_e = '0; ns_e = '0; te_e = '0;
    for (int c = 1; c < 20; c++) mute_e[c] = !((c >= 3 && c <= 10) || (c >= 13 && c <= 16));
    ns_e[3] = 1'b1; ns_e[13] = 1'b1; te_e[19] = 1'b1;
    check("trace_mute", int'(mute_v), int'(mute_e));
    check("trace_note_start", int'(ns_v), int'(ns_e));
    check("trace_track_end", int'(te_v), int'(te_e));
    check("trace_end_track", int'(bus.track_sel), 1);
    check("trace_end_addr", int'(bus.note_addr), 0);

    // Pause in the middle of a 2-tick note and resume.
    fill_rom(0);
    rom[0][0] = 4'd2;
    do_reset();
    bus.play = 1'b1;
    wait_note("pause_start");
    repeat (3) tick();
    bus.play = 1'b0;
    muted_lo = 0;
    repeat (20) begin tick(); if (!bus.mute) muted_lo++; end
    check("pause_mute_low", muted_lo, 0);
    check("pause_addr", int'(bus.note_addr), 0);
    bus.play = 1'b1;
    n = 0; run = 0;
    while (bus.note_addr == 6'd0 && n < 60) begin tick(); n++; if (!bus.mute) run++; end
    check("pause_resume_cycles", run, 5);
    check("pause_addr_next", int'(bus.note_addr), 1);

    // Next/prev buttons.
    fill_rom(3);
    do_reset();
    bus.play = 1'b1;
    wait_note("btn_first");
    bus.btn_next = 1'b1; tick(); bus.btn_next = 1'b0;
    check("next_from0", int'(bus.track_sel), 1);
    wait_note("btn_t1_a0");
    wait_note("btn_t1_a1");
    check("btn_pre_addr", int'(bus.note_addr), 1);
    tick();
    bus.btn_next = 1'b1; tick(); bus.btn_next = 1'b0;
    check("next_track", int'(bus.track_sel), 2);
    check("next_addr", int'(bus.note_addr), 0);
    check("next_mute", int'(bus.mute), 1);
    tick();
    check("next_fetch_mute", int'(bus.mute), 1);
    tick();
    check("next_note_start", int'(bus.note_start), 1);
    do_reset();
    bus.play = 1'b1;
    wait_note("prev_first");
    bus.btn_prev = 1'b1; tick();
    check("prev_track", int'(bus.track_sel), 3);
    check("prev_addr", int'(bus.note_addr), 0);
    repeat (3) tick();
    check("prev_held", int'(bus.track_sel), 3);
    bus.btn_prev = 1'b0;
    wait_note("both_first");
    tick();
    bus.btn_next = 1'b1; bus.btn_prev = 1'b1; tick();
    check("both_track", int'(bus.track_sel), 3);
    check("both_mute", int'(bus.mute), 0);
    bus.btn_next = 1'b0; bus.btn_prev = 1'b0;

    // 64 one-tick notes with no marker roll over to the next track.
    fill_rom(1);
    do_reset();
    bus.play = 1'b1;
    n = 0; ns = 0; last = -1;
    while (!bus.track_end && n < 600) begin
      tick(); n++;
      if (bus.note_start) begin ns++; last = int'(bus.note_addr); end
    end
    check("full_end_seen", int'(bus.track_end), 1);
    check("full_notes", ns, 64);
    check("full_last_addr", last, 63);
    check("full_track", int'(bus.track_sel), 1);
    check("full_addr", int'(bus.note_addr), 0);

    // Reset between clock edges mid-PLAY.
    fill_rom(3);
    do_reset();
    bus.play = 1'b1;
    wait_note("arst_a");
    bus.btn_next = 1'b1; tick(); bus.btn_next = 1'b0;
    wait_note("arst_b");
    wait_note("arst_c");
    tick();
    #2 reset = 1'b1;
    #1;
    check("arst_mute", int'(bus.mute), 1);
    check("arst_addr", int'(bus.note_addr), 0);
    check("arst_track", int'(bus.track_sel), 0);
    check("arst_note_start", int'(bus.note_start), 0);
    tick();
    reset = 1'b0;

    // Randomized songs with random pauses, scored against the song model.
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int t = 0; t < 4; t++)
        for (int a = 0; a < 64; a++) rom[t][a] = 4'($urandom_range(1, 4));
      for (int t = 0; t < 4; t++)
        if ($urandom_range(0, 3) != 0) rom[t][$urandom_range(1, 24)] = 4'd0;
      exp_q.delete();
      push_song();
      open_n = 1'b0;
      mon_en = 1'b1;
      bus.play = 1'b1;
      ph = 0; cyc = 0;
      while (exp_q.size() > 0 && cyc < 12000) begin
        tick(); cyc++;
        if (ph == 0 && bus.note_start && $urandom_range(0, 1) == 1) begin
          d = int'(rom[bus.track_sel][bus.note_addr]);
          if (d > 0) begin
            kc = $urandom_range(0, d * TD - 1);
            ph = 1;
          end
        end
        if (ph == 1) begin
          if (kc == 0) begin bus.play = 1'b0; mc = $urandom_range(1, 6); ph = 2; end
          else kc--;
        end else if (ph == 2) begin
          if (mc == 0) begin bus.play = 1'b1; ph = 0; end
          else mc--;
        end
      end
      mon_en = 1'b0;
      bus.play = 1'b0;
      check("sb_drained", exp_q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/playback_controller.md
PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
REQ-001 Parameter TICK_DIV, default 4: clock cycles per duration tick; legal range >= 2.
REQ-002 Parameter NOTE_W, default 6: note address width, giving 64 notes per track.
REQ-003 Parameter TRACK_W, default 2: track select width, giving 4 tracks.
REQ-004 Port clk, input, 1: single clock; all registers update on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port play, input, 1: level input from the play/pause FSM; 1 = play, 0 = pause.
REQ-007 Port btn_next, input, 1: next-track button level.
REQ-008 Port btn_prev, input, 1: previous-track button level.
REQ-009 Port note_dur, input, 4: note duration in ticks from the song ROM, valid one cycle after note_addr/track_sel change; 0 = end-of-track marker.
REQ-010 Port note_addr, output, NOTE_W: registered ROM note address.
REQ-011 Port track_sel, output, TRACK_W: registered ROM track select.
REQ-012 Port mute, output, 1: 1 silences the tone generator; 0 only in PLAY.
REQ-013 Port note_start, output, 1: one-cycle pulse on each FETCH->PLAY entry.
REQ-014 Port track_end, output, 1: one-cycle pulse when a track ends.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, FETCH, PLAY, PAUSE.
REQ-016 IDLE: mute=1; play=1 -> WAIT.
REQ-017 WAIT SHALL last exactly 1 cycle, then go to FETCH; it gives the ROM its read latency.
REQ-018 FETCH SHALL sample note_dur into dur_reg, clear dur_cnt and the prescaler, and take exactly 1 cycle.
REQ-019 FETCH exit: note_dur=0 -> end-of-track; otherwise PLAY if play=1, else PAUSE.
REQ-020 End-of-track: track_sel+1 (wraps at max), note_addr=0, track_end=1 for 1 cycle, next state WAIT.
REQ-021 PLAY: the prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs on the cycle it equals TICK_DIV-1.
REQ-022 On a tick with dur_cnt = dur_reg-1, the note SHALL end; otherwise dur_cnt increments on the tick.
REQ-023 Each note SHALL occupy exactly dur_reg*TICK_DIV cycles in PLAY, with mute=0.
REQ-024 Note end: note_addr+1, next state WAIT.
REQ-025 Note end at note_addr = 2^NOTE_W-1: treated as end-of-track (REQ-020); note_addr SHALL NOT wrap inside a track.
REQ-026 PLAY with play=0: next state PAUSE; prescaler and dur_cnt frozen; that cycle's tick/note end is discarded.
REQ-027 PAUSE: mute=1, all counters held; play=1 -> PLAY, resuming the remaining cycles of the note exactly.
REQ-028 btn_next and btn_prev SHALL each be edge-detected internally with one registered sample; an event is a 0->1 transition.
REQ-029 Next event: track_sel+1 with wrap. Prev event: track_sel-1 with wrap (0 -> 2^TRACK_W-1).
REQ-030 On either event: note_addr=0, dur_cnt=0, prescaler=0.
REQ-031 State after a next/prev event: WAIT if current state is WAIT, FETCH or PLAY; IDLE if current state is IDLE or PAUSE.
REQ-032 Next and prev events in the same cycle SHALL both be ignored.
REQ-033 Priority within a cycle: reset > next/prev > play=0 pause > note end/end-of-track.
REQ-034 A next/prev event in FETCH SHALL discard the sampled note_dur.
REQ-035 note_start and track_end SHALL never assert in the same cycle.

Reset
REQ-036 Reset SHALL immediately set state=IDLE, note_addr=0, track_sel=0, mute=1, note_start=0, track_end=0, dur_reg=0, dur_cnt=0, prescaler=0.
REQ-037 Reset SHALL set both button edge samples to 0.
REQ-038 Reset asserted mid-PLAY SHALL force the reset values asynchronously, without waiting for a clock edge.

Verification (TICK_DIV=4)
REQ-039 Release reset with play=0 -> note_addr=0, track_sel=0, mute=1, state stays IDLE.
REQ-040 ROM track 0 = {2,1,0}; set play=1:
- WAIT, then FETCH, then note_start.
- mute=0 for 8 cycles at addr 0, then mute=1 for 2 cycles.
- mute=0 for 4 cycles at addr 1.
- Then addr 2 is fetched: track_end pulses, track_sel=1, note_addr=0.
REQ-041 dur=2, drop play after 3 PLAY cycles, hold 20 cycles, raise play -> mute=1 and addr held during the pause; then exactly 5 more mute=0 cycles before addr increments.
REQ-042 Track 1 in PLAY, btn_next 0->1 -> track_sel=2, note_addr=0, WAIT. Same from track 0 with btn_prev -> track_sel=3. Both rising in the same cycle -> no change.
REQ-043 All 64 notes of a track with dur=1 and no marker -> after addr 63, track_sel increments and note_addr=0.
REQ-044 Assert reset mid-PLAY, between clock edges -> mute=1, note_addr=0, track_sel=0 before the next clk edge.
